// File: rtl/shreg_pkg.sv
// rtl/shreg_pkg.sv - shared mode encodings and burst FSM states for shift_reg_univ
package shreg_pkg;

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_SHR  = 3'b011;
    localparam logic [2:0] MODE_ROTL = 3'b100;
    localparam logic [2:0] MODE_ROTR = 3'b101;
    localparam logic [2:0] MODE_ASR  = 3'b110;
    localparam logic [2:0] MODE_CLR  = 3'b111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Only the shift-class modes can be repeated as a burst.
    function automatic logic is_shift_mode(input logic [2:0] m);
        return (m >= MODE_SHL) && (m <= MODE_ASR);
    endfunction

endpackage

// File: rtl/shreg_burst_ctrl.sv
// rtl/shreg_burst_ctrl.sv - burst FSM and shift counter steering the shift register datapath
module shreg_burst_ctrl
    import shreg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          start,
    input  logic [2:0]    mode,
    input  logic [CW-1:0] count,
    output logic          busy,
    output logic          done,
    output logic          op_en,
    output logic [2:0]    op_mode
);

    state_t        state;
    logic [CW-1:0] rem;
    logic [2:0]    lat_mode;
    logic [CW-1:0] count_sat;
    logic          burst_req;

    always_comb begin
        count_sat = count;
        if (count > CW'(WIDTH)) begin
            count_sat = CW'(WIDTH);
        end
    end

    assign burst_req = start && is_shift_mode(mode);
    assign busy      = (state == ST_BUSY);

    // A burst request consumes its start cycle without touching q.
    assign op_en   = en && (busy || !burst_req);
    assign op_mode = busy ? lat_mode : mode;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            rem      <= '0;
            lat_mode <= MODE_HOLD;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (en) begin
                case (state)
                    ST_IDLE: begin
                        if (burst_req) begin
                            if (count_sat == '0) begin
                                done <= 1'b1;
                            end else begin
                                state    <= ST_BUSY;
                                rem      <= count_sat;
                                lat_mode <= mode;
                            end
                        end
                    end
                    ST_BUSY: begin
                        if (rem <= CW'(1)) begin
                            state <= ST_IDLE;
                            rem   <= '0;
                            done  <= 1'b1;
                        end else begin
                            rem <= rem - CW'(1);
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/shift_reg_univ.sv
// rtl/shift_reg_univ.sv - universal shift register with load/shift/rotate modes and counted bursts
module shift_reg_univ
    import shreg_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    localparam int              CW      = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_l,
    input  logic             sin_r,
    input  logic             start,
    input  logic [CW-1:0]    count,
    output logic [WIDTH-1:0] q,
    output logic             sout_l,
    output logic             sout_r,
    output logic             busy,
    output logic             done
);

    logic             op_en;
    logic [2:0]       op_mode;
    logic [WIDTH-1:0] q_nxt;

    shreg_burst_ctrl #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_ctrl (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .start   (start),
        .mode    (mode),
        .count   (count),
        .busy    (busy),
        .done    (done),
        .op_en   (op_en),
        .op_mode (op_mode)
    );

    always_comb begin
        q_nxt = q;
        case (op_mode)
            MODE_HOLD: q_nxt = q;
            MODE_LOAD: q_nxt = d;
            MODE_SHL:  q_nxt = {q[WIDTH-2:0], sin_l};
            MODE_SHR:  q_nxt = {sin_r, q[WIDTH-1:1]};
            MODE_ROTL: q_nxt = {q[WIDTH-2:0], q[WIDTH-1]};
            MODE_ROTR: q_nxt = {q[0], q[WIDTH-1:1]};
            MODE_ASR:  q_nxt = {q[WIDTH-1], q[WIDTH-1:1]};
            MODE_CLR:  q_nxt = '0;
            default:   q_nxt = q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= RST_VAL;
        end else if (op_en) begin
            q <= q_nxt;
        end
    end

    assign sout_l = q[WIDTH-1];
    assign sout_r = q[0];

endmodule

// File: tb/tb_shift_reg_univ.sv
// tb/tb_shift_reg_univ.sv - scoreboard bench for shift_reg_univ against an arithmetic reference model
module tb_shift_reg_univ;
    import shreg_pkg::*;

    localparam logic [7:0] RV = 8'hA5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [2:0] mode = 3'd0;
    logic [7:0] d = 8'd0;
    logic       sin_l = 1'b0;
    logic       sin_r = 1'b0;
    logic       start = 1'b0;
    logic [3:0] count = 4'd0;
    logic [7:0] q;
    logic       sout_l, sout_r, busy, done;

    shift_reg_univ #(.WIDTH(8), .RST_VAL(RV)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d),
        .sin_l(sin_l), .sin_r(sin_r), .start(start), .count(count),
        .q(q), .sout_l(sout_l), .sout_r(sout_r), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] q;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_pass = 0;
    int   n_total = 0;

    int m_q = RV;
    bit m_busy = 0;
    int m_rem = 0;
    int m_bmode = 0;
    bit m_done = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic int apply(input int m, input int v, input int dv, input int sl, input int sr);
        case (m)
            0: return v;
            1: return dv;
            2: return (v * 2 + sl) % 256;
            3: return v / 2 + sr * 128;
            4: return (v * 2) % 256 + v / 128;
            5: return v / 2 + (v % 2) * 128;
            6: return v / 2 + (v / 128) * 128;
            default: return 0;
        endcase
    endfunction

    // Reference: what the register looks like after the coming edge.
    task automatic model_edge();
        int n;
        m_done = 0;
        if (en) begin
            if (m_busy) begin
                m_q = apply(m_bmode, m_q, int'(d), int'(sin_l), int'(sin_r));
                m_rem--;
                if (m_rem == 0) begin
                    m_busy = 0;
                    m_done = 1;
                end
            end else if (start && mode >= 3'd2 && mode <= 3'd6) begin
                n = (count > 4'd8) ? 8 : int'(count);
                if (n == 0) m_done = 1;
                else begin
                    m_busy = 1;
                    m_rem = n;
                    m_bmode = int'(mode);
                end
            end else begin
                m_q = apply(int'(mode), m_q, int'(d), int'(sin_l), int'(sin_r));
            end
        end
    endtask

    task automatic model_reset();
        m_q = RV;
        m_busy = 0;
        m_rem = 0;
        m_done = 0;
    endtask

    task automatic step(input logic e, input logic [2:0] m, input logic [7:0] dv,
                        input logic sl, input logic sr, input logic st, input logic [3:0] c);
        @(negedge clk);
        en = e; mode = m; d = dv; sin_l = sl; sin_r = sr; start = st; count = c;
        model_edge();
        sb.push_back('{q: 8'(m_q), busy: m_busy, done: m_done});
        @(posedge clk);
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            check("sb q/busy/done/sout", {52'd0, q, busy, done, sout_l, sout_r},
                  {52'd0, mon_e.q, mon_e.busy, mon_e.done, mon_e.q[7], mon_e.q[0]});
        end
    end

    task automatic run_burst(input logic [2:0] bm, input logic [3:0] cnt, input logic sl,
                             input int stall_at, input bit junk, input int b2b_at,
                             output int nbusy, output int ndone, output int done_idx,
                             output logic [7:0] qd);
        logic e;
        nbusy = 0; ndone = 0; done_idx = -1; qd = 8'h00;
        for (int i = 0; i < 20; i++) begin
            e = !(stall_at > 0 && (i == stall_at || i == stall_at + 1));
            if (i == 0 || i == b2b_at) step(1'b1, bm, 8'h00, sl, sl, 1'b1, cnt);
            else if (junk) step(1'b1, MODE_LOAD, 8'($urandom), sl, sl, 1'b1, 4'($urandom));
            else step(e, MODE_HOLD, 8'h00, sl, sl, 1'b0, 4'd0);
            #2;
            if (busy) nbusy++;
            if (done) begin
                if (ndone == 0) done_idx = i;
                qd = q;
                ndone++;
            end
        end
    endtask

    logic [2:0] mt_mode [6] = '{MODE_LOAD, MODE_ROTL, MODE_ROTR, MODE_ASR, MODE_SHL, MODE_CLR};
    logic       mt_sl   [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [7:0] mt_exp  [6] = '{8'h96, 8'h2D, 8'h96, 8'hCB, 8'h97, 8'h00};

    initial begin
        int nb, nd, di;
        logic [7:0] qd;

        #2 rst = 1'b0;
        #1;
        check("reset q", 64'(q), 64'(RV));
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();

        for (int i = 0; i < 6; i++) begin
            step(1'b1, mt_mode[i], 8'h96, mt_sl[i], 1'b0, 1'b0, 4'd0);
            #2 check("mode seq q", 64'(q), 64'(mt_exp[i]));
        end

        step(1'b1, MODE_LOAD, 8'h01, 1'b0, 1'b0, 1'b0, 4'd0);
        run_burst(MODE_SHL, 4'd3, 1'b0, -1, 1'b0, -1, nb, nd, di, qd);
        check("burst3 busy cycles", 64'(nb), 64'd3);
        check("burst3 done index", 64'(di), 64'd3);
        check("burst3 done count", 64'(nd), 64'd1);
        check("burst3 q", 64'(qd), 64'h08);

        step(1'b1, MODE_LOAD, 8'h01, 1'b0, 1'b0, 1'b0, 4'd0);
        run_burst(MODE_SHL, 4'd4, 1'b0, 2, 1'b0, -1, nb, nd, di, qd);
        check("stall busy cycles", 64'(nb), 64'd6);
        check("stall done index", 64'(di), 64'd6);
        check("stall q", 64'(qd), 64'h10);

        step(1'b1, MODE_LOAD, 8'h80, 1'b0, 1'b0, 1'b0, 4'd0);
        run_burst(MODE_SHR, 4'd2, 1'b0, -1, 1'b0, 3, nb, nd, di, qd);
        check("b2b done count", 64'(nd), 64'd2);
        check("b2b busy cycles", 64'(nb), 64'd4);
        check("b2b q", 64'(qd), 64'h08);

        step(1'b1, MODE_LOAD, 8'h5A, 1'b0, 1'b0, 1'b0, 4'd0);
        run_burst(MODE_ROTL, 4'd0, 1'b0, -1, 1'b0, -1, nb, nd, di, qd);
        check("cnt0 done index", 64'(di), 64'd0);
        check("cnt0 busy cycles", 64'(nb), 64'd0);
        check("cnt0 q", 64'(qd), 64'h5A);

        step(1'b1, MODE_LOAD, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0);
        run_burst(MODE_SHL, 4'd15, 1'b1, -1, 1'b0, -1, nb, nd, di, qd);
        check("cnt15 busy cycles", 64'(nb), 64'd8);
        check("cnt15 done index", 64'(di), 64'd8);
        check("cnt15 q", 64'(qd), 64'hFF);

        step(1'b1, MODE_LOAD, 8'h81, 1'b0, 1'b0, 1'b0, 4'd0);
        run_burst(MODE_ROTR, 4'd3, 1'b0, -1, 1'b1, -1, nb, nd, di, qd);
        check("busy start ignored index", 64'(di), 64'd3);
        check("busy start ignored q", 64'(qd), 64'h30);

        // Abort a 5-shift burst after two shifts with an asynchronous reset.
        step(1'b1, MODE_LOAD, 8'h01, 1'b0, 1'b0, 1'b0, 4'd0);
        step(1'b1, MODE_SHL, 8'h00, 1'b0, 1'b0, 1'b1, 4'd5);
        step(1'b1, MODE_HOLD, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0);
        step(1'b1, MODE_HOLD, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0);
        #2 check("pre-abort q", 64'(q), 64'h04);
        check("pre-abort busy", 64'(busy), 64'd1);
        #1 rst = 1'b0;
        #1;
        check("abort q", 64'(q), 64'(RV));
        check("abort busy", 64'(busy), 64'd0);
        check("abort done", 64'(done), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        nd = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, MODE_HOLD, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0);
            #2 if (done) nd++;
        end
        check("no done after abort", 64'(nd), 64'd0);
        check("q held after abort", 64'(q), 64'(RV));

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 7) != 0, 3'($urandom), 8'($urandom),
                 1'($urandom), 1'($urandom), $urandom_range(0, 4) == 0,
                 4'($urandom_range(0, 15)));
        end

        @(negedge clk);
        @(negedge clk);
        check("scoreboard drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/shift_reg_univ.md
SHIFT_REG_UNIV -- requirements
Module: shift_reg_univ

Interface
REQ-001 SHALL have parameter WIDTH, default 8, register width in bits (legal range 2..64).
REQ-002 SHALL have parameter RST_VAL, default 0, WIDTH-bit value loaded into q on reset.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port en  input  1  clock enable; 0 freezes q and the burst counter.
REQ-006 SHALL have port mode  input  3  operation select (see REQ-010).
REQ-007 SHALL have ports d  input  WIDTH  parallel load data; sin_l / sin_r  input  1  serial inputs entering at bit 0 / bit WIDTH-1.
REQ-008 SHALL have ports start  input  1  burst request; count  input  CW=$clog2(WIDTH+1)  burst shift count.
REQ-009 SHALL have ports q  output  WIDTH  register contents; sout_l / sout_r  output  1  equal to q[WIDTH-1] / q[0]; busy  output  1  burst in progress; done  output  1  one-cycle burst-complete pulse.

Function
REQ-010 SHALL decode mode as: 000 hold, 001 load d, 010 shl (sin_l into bit 0), 011 shr (sin_r into MSB), 100 rotl, 101 rotr, 110 asr (MSB replicated), 111 clear to 0.
REQ-011 SHALL, when idle, en=1 and start=0, apply mode to q with one-cycle latency.
REQ-012 SHALL, when idle, en=1 and start=1, latch count and shift-class mode (010..110) and enter BUSY; start with mode 000/001/111 SHALL be treated as a single normal mode operation, no burst.
REQ-013 SHALL, in BUSY with en=1, perform the latched shift once per cycle and decrement the remaining count; mode, d and start are ignored.
REQ-014 SHALL deassert busy and pulse done for exactly one cycle in the cycle following the final shift.
REQ-015 SHALL, for count=0, enter no shifts, assert done one cycle after start, leave q unchanged.
REQ-016 SHALL saturate count values greater than WIDTH to WIDTH.
REQ-017 SHALL, with en=0, hold q, busy and remaining count; done SHALL NOT be asserted while en=0.
REQ-018 SHALL ignore start while busy=1; a start in the same cycle done is high SHALL be accepted.
REQ-019 SHALL use FSM states IDLE and BUSY only; done is a registered output.

Reset
REQ-020 SHALL, on rst=0, asynchronously set q=RST_VAL, busy=0, done=0, remaining count=0, state=IDLE, regardless of clk or en.
REQ-021 SHALL abort any burst on reset mid-operation; no done pulse SHALL follow release of reset.
REQ-022 SHALL resume normal operation on the first rising clk edge after rst returns to 1.

Structure
REQ-023 SHALL take mode encodings (MODE_HOLD..MODE_CLR) and the FSM state enumeration from shared package shreg_pkg.
REQ-024 SHALL implement the burst FSM and counter in one sub-module shreg_burst_ctrl; the data path (mode mux and q register) SHALL remain in shift_reg_univ.

Verification
REQ-025 SHALL verify reset: rst=0 asynchronously mid-cycle with WIDTH=8, RST_VAL=8'hA5 -> q=8'hA5, busy=0, done=0 immediately, before next clk.
REQ-026 SHALL verify modes: load 8'b1001_0110, then rotl -> 8'b0010_1101, rotr -> 8'b1001_0110, asr -> 8'b1100_1011, shl with sin_l=1 -> 8'b1001_0111, clear -> 8'h00.
REQ-027 SHALL verify burst: q=8'h01, start with mode shl, count=3, sin_l=0 -> busy for 3 cycles, q=8'h08, done high exactly one cycle after the third shift.
REQ-028 SHALL verify stall and back-to-back: burst count=4 with en=0 for 2 cycles mid-burst -> total 6 cycles busy, q correct; start asserted with done -> second burst accepted.
REQ-029 SHALL verify boundaries: count=0 -> done after 1 cycle, q unchanged; count=15 with WIDTH=8 -> exactly 8 shifts; start while busy -> ignored.
REQ-030 SHALL verify reset mid-burst: rst=0 after 2 of 5 shifts -> q=RST_VAL, busy=0, no done pulse after release.
